// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 5x-oversampled UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Each bit is decided by a majority vote of three mid-bit samples; one-entry output register with ack.
module uart_rx_ovs #(
    parameter int CLK_DIV = 20
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       PARITY_ERR
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [11:0] TICK_LAST = 12'(CLK_DIV - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus the received parity bit must XOR to zero.
    function automatic logic even_parity_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    logic        rxd_meta_r, rxd_sync_r, rxd_prev_r;
    state_t      state_r, state_nxt_s;
    logic [11:0] cnt_r, cnt_nxt_s;
    logic [2:0]  ph_r, ph_nxt_s;
    logic [2:0]  bit_r, bit_nxt_s;
    logic [1:0]  smp_r, smp_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [7:0]  rx_data_r, rx_data_nxt_s;
    logic        rx_valid_r, rx_valid_nxt_s;
    logic        frame_err_r, frame_err_nxt_s;
    logic        overrun_r, overrun_nxt_s;
    logic        tick_s, dec_s, end_s, vote_s, perr_s;
`ifdef UART_RX_PARITY_EN
    logic        par_r, par_nxt_s;
    logic        parity_err_r, parity_err_nxt_s;
`endif

    // ph_r counts ticks already seen in the current bit, so tick number = ph_r + 1.
    assign tick_s = (state_r != IDLE) && (cnt_r == TICK_LAST);
    assign dec_s  = tick_s && (ph_r == 3'd3);
    assign end_s  = tick_s && (ph_r == 3'd4);
    assign vote_s = majority3(smp_r[0], smp_r[1], rxd_sync_r);
`ifdef UART_RX_PARITY_EN
    assign perr_s = even_parity_err(shift_r, par_r);
`else
    assign perr_s = 1'b0;
`endif

    // Synchronize the asynchronous line and keep one extra stage for falling-edge detection.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= RXD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Next-state, datapath and output decode for the receive FSM.
    always_comb begin
        state_nxt_s     = state_r;
        bit_nxt_s       = bit_r;
        shift_nxt_s     = shift_r;
        rx_data_nxt_s   = rx_data_r;
        frame_err_nxt_s = 1'b0;
        overrun_nxt_s   = 1'b0;
        cnt_nxt_s       = cnt_r;
        ph_nxt_s        = ph_r;
        smp_nxt_s       = smp_r;
`ifdef UART_RX_PARITY_EN
        par_nxt_s        = par_r;
        parity_err_nxt_s = 1'b0;
`endif
        if (RX_ACK) begin
            rx_valid_nxt_s = 1'b0;
        end else begin
            rx_valid_nxt_s = rx_valid_r;
        end

        if (tick_s && (ph_r == 3'd1)) begin
            smp_nxt_s[0] = rxd_sync_r;
        end else if (tick_s && (ph_r == 3'd2)) begin
            smp_nxt_s[1] = rxd_sync_r;
        end else begin
            smp_nxt_s = smp_r;
        end

        case (state_r)
            IDLE: begin
                if (rxd_prev_r && !rxd_sync_r) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (dec_s && vote_s) begin
                    state_nxt_s = IDLE;
                end else if (end_s) begin
                    state_nxt_s = DATA;
                    bit_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (dec_s) begin
                    shift_nxt_s = {vote_s, shift_r[7:1]};
                end else begin
                    shift_nxt_s = shift_r;
                end
                if (end_s && (bit_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt_s = PARITY;
`else
                    state_nxt_s = STOP;
`endif
                end else if (end_s) begin
                    bit_nxt_s = bit_r + 3'd1;
                end else begin
                    bit_nxt_s = bit_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (dec_s) begin
                    par_nxt_s = vote_s;
                end else begin
                    par_nxt_s = par_r;
                end
                if (end_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
`endif
            STOP: begin
                // Leave at tick 4 so a following start edge is not missed.
                if (dec_s) begin
                    state_nxt_s = IDLE;
                    if (!vote_s) begin
                        frame_err_nxt_s = 1'b1;
                    end else if (perr_s) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_nxt_s = 1'b1;
`endif
                    end else if (!rx_valid_r || RX_ACK) begin
                        rx_data_nxt_s  = shift_r;
                        rx_valid_nxt_s = 1'b1;
                    end else begin
                        overrun_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        if ((state_r == IDLE) || (state_nxt_s == IDLE)) begin
            cnt_nxt_s = 12'd0;
            ph_nxt_s  = 3'd0;
        end else if (tick_s) begin
            cnt_nxt_s = 12'd0;
            ph_nxt_s  = (ph_r == 3'd4) ? 3'd0 : (ph_r + 3'd1);
        end else begin
            cnt_nxt_s = cnt_r + 12'd1;
            ph_nxt_s  = ph_r;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            cnt_r       <= 12'd0;
            ph_r        <= 3'd0;
            bit_r       <= 3'd0;
            smp_r       <= 2'b11;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r        <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ph_r        <= ph_nxt_s;
            bit_r       <= bit_nxt_s;
            smp_r       <= smp_nxt_s;
            shift_r     <= shift_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            rx_valid_r  <= rx_valid_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            overrun_r   <= overrun_nxt_s;
`ifdef UART_RX_PARITY_EN
            par_r        <= par_nxt_s;
            parity_err_r <= parity_err_nxt_s;
`endif
        end
    end

    assign RX_DATA   = rx_data_r;
    assign RX_VALID  = rx_valid_r;
    assign FRAME_ERR = frame_err_r;
    assign OVERRUN   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = parity_err_r;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule
